bcd_seq_adder: RTL and testbench
================================

BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the number of packed-BCD bytes per operand (2 digits per byte, so 8 digits by default).
REQ-002 SHALL have port clk, input, 1 bit: the single clock. All state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled only in IDLE.
REQ-005 SHALL have port op_a, input, 8*NBYTES bits: packed-BCD addend, least significant byte in [7:0].
REQ-006 SHALL have port op_b, input, 8*NBYTES bits: packed-BCD addend, same layout as op_a.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port sum, output, 8*NBYTES bits: packed-BCD result, held until the next accepted start.
REQ-010 SHALL have port cout, output, 1 bit: decimal carry out of the most significant digit.
REQ-011 SHALL have port err, output, 1 bit: high if any operand nibble of the current or last operation exceeded 9.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN, using one shared 2-digit BCD byte adder serially over the operands.
REQ-013 In IDLE with start=1 at a rising edge, SHALL make the following updates in that same edge:
  - capture op_a and op_b into internal shift registers;
  - clear carry, the byte index, the sum register and err;
  - go to RUN.
REQ-014 In RUN, each rising edge SHALL process one byte:
  - add byte[idx] of A, byte[idx] of B and the carry;
  - write the 2-digit BCD result into sum byte idx;
  - register the byte carry-out as the carry for the next byte.
REQ-015 The byte adder SHALL apply per-digit correction: if the binary digit sum exceeds 9 or produces a carry, add 6 and carry 1 into the next digit.
REQ-016 SHALL process bytes LSB first, idx 0 to NBYTES-1, in exactly NBYTES RUN cycles.
REQ-017 On the edge that processes byte NBYTES-1, SHALL:
  - return to IDLE;
  - set cout to the final carry;
  - assert done for exactly the following cycle.
REQ-018 Latency SHALL be fixed: if start is accepted at edge 0, done is high between edge NBYTES and edge NBYTES+1, regardless of data.
REQ-019 busy SHALL be high from edge 0 until edge NBYTES, and low otherwise.
REQ-020 start while busy SHALL be ignored, with no effect on the operands, state or outputs.
REQ-021 start high in the done cycle SHALL be accepted, since the FSM is already in IDLE, giving back-to-back operations with no gap cycle.
REQ-022 err SHALL be set, and stay set until the next accepted start, when any processed nibble of A or B is greater than 9.
REQ-023 When err is set, the computation SHALL still complete with the same correction rule and the same latency.
REQ-024 sum and cout SHALL be stable in IDLE; they change only on RUN edges and on an accepted start.
REQ-025 Maximum input 99..9 + 99..9 SHALL give sum 99..98 with cout=1.
REQ-026 Carry SHALL propagate across byte boundaries; for example 0x0099 + 0x0001 = 0x0100.

Reset
REQ-027 While rst_n=0, SHALL hold the following asynchronously:
  - state=IDLE;
  - busy=0, done=0, cout=0, err=0;
  - sum=0;
  - carry=0, idx=0;
  - operand registers=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation, with no done pulse afterwards.
REQ-029 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-030 A shared package bcd_pkg SHALL hold:
  - the FSM state enum (IDLE, RUN);
  - BCD_MAX=9;
  - BCD_ADJ=6;
  - the default NBYTES.
REQ-031 SHALL instantiate one combinational sub-module, bcd_byte_add, with:
  - inputs: a[7:0], b[7:0], cin;
  - outputs: s[7:0], cout, bad (a nibble greater than 9).
REQ-032 The controller SHALL contain no more than one instance of bcd_byte_add; serial reuse is required.

Verification (NBYTES=2)
REQ-033 op_a=0x0025, op_b=0x0052, start pulse -> done 2 edges later; sum=0x0077, cout=0, err=0.
REQ-034 0x0099 + 0x0088 -> sum=0x0187, cout=0; then 0x9999 + 0x0001 -> sum=0x0000, cout=1.
REQ-035 0x0093 + 0x0012 started, then start held high through the done cycle with new operands 0x0001 + 0x0001:
  - first operation -> sum=0x0105;
  - second operation is accepted back-to-back -> sum=0x0002;
  - start asserted while busy causes no extra operation.
REQ-036 op_a=0x00A0, op_b=0x0000 -> err=1 at done, latency unchanged; the next valid start clears err.
REQ-037 rst_n pulsed low one edge after start -> busy=0, done never pulses, sum=0; a new start afterwards completes correctly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
//   state_t     : controller state encoding (IDLE, RUN)
//   BCD_MAX     : largest legal decimal digit
//   BCD_ADJ     : correction added to a digit sum that leaves the 0-9 range
//   NBYTES_DEF  : default operand width in packed-BCD bytes
package bcd_pkg;

    localparam int         NBYTES_DEF = 4;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] BCD_ADJ    = 4'd6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_byte_add.sv
// Combinational two-digit packed-BCD adder.
// Ports:
//   a, b  [7:0] in  : packed-BCD bytes (high digit in [7:4])
//   cin         in  : decimal carry into the low digit
//   s     [7:0] out : packed-BCD byte result
//   cout        out : decimal carry out of the high digit
//   bad         out : some nibble of a or b is greater than 9
module bcd_byte_add
    import bcd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       bad
);

    logic [4:0] lo_raw;
    logic [4:0] hi_raw;
    logic       lo_c;
    logic [3:0] lo_dig;
    logic [3:0] hi_dig;

    // A 5-bit digit sum above 9 covers both the 10..15 case and a binary
    // carry out of the nibble; the +6 then wraps the digit back into 0-9.
    always_comb begin
        lo_raw = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0000, cin};
        lo_c   = (lo_raw > {1'b0, BCD_MAX});
        lo_dig = lo_c ? (lo_raw[3:0] + BCD_ADJ) : lo_raw[3:0];

        hi_raw = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0000, lo_c};
        cout   = (hi_raw > {1'b0, BCD_MAX});
        hi_dig = cout ? (hi_raw[3:0] + BCD_ADJ) : hi_raw[3:0];

        s      = {hi_dig, lo_dig};
        bad    = (a[3:0] > BCD_MAX) || (a[7:4] > BCD_MAX) ||
                 (b[3:0] > BCD_MAX) || (b[7:4] > BCD_MAX);
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Serial packed-BCD adder: one shared two-digit byte adder is applied to
// one byte per clock, least significant byte first.
// Ports:
//   clk                   in  : clock, rising edge
//   rst_n                 in  : asynchronous active-low reset
//   start                 in  : operation request, only looked at in IDLE
//   op_a, op_b [8*NBYTES] in  : packed-BCD addends, LS byte in [7:0]
//   busy                  out : operation in progress
//   done                  out : one-cycle completion pulse
//   sum        [8*NBYTES] out : packed-BCD result, held until next start
//   cout                  out : decimal carry out of the MS digit
//   err                   out : an operand nibble above 9 was seen
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; sum/cout/err hold the last result
// RUN   | adding byte idx of the captured operands, one per edge
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t         state;
    state_t         state_nxt;

    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   sum_r;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           cout_r;
    logic           err_r;
    logic           done_r;

    logic [7:0]     byte_s;
    logic           byte_c;
    logic           byte_bad;
    logic           accept;
    logic           last;

    assign accept = (state == IDLE) && start;
    assign last   = (state == RUN) && (idx == LAST_IDX);

    // Operands are shifted right every RUN cycle, so the byte being worked
    // on always sits in [7:0] and the adder needs no wide input mux.
    bcd_byte_add u_byte_add (
        .a    (a_sh[7:0]),
        .b    (b_sh[7:0]),
        .cin  (carry),
        .s    (byte_s),
        .cout (byte_c),
        .bad  (byte_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST_IDX) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= last;
            if (accept) begin
                a_sh   <= op_a;
                b_sh   <= op_b;
                sum_r  <= '0;
                idx    <= '0;
                carry  <= 1'b0;
                cout_r <= 1'b0;
                err_r  <= 1'b0;
            end else if (state == RUN) begin
                a_sh              <= a_sh >> 8;
                b_sh              <= b_sh >> 8;
                sum_r[8*idx +: 8] <= byte_s;
                carry             <= byte_c;
                err_r             <= err_r | byte_bad;
                idx               <= last ? '0 : idx + IW'(1);
                if (last) begin
                    cout_r <= byte_c;
                end
            end
        end
    end

    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign err  = err_r;

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder with NBYTES=2.
module tb_bcd_seq_adder;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_seq_adder #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Digit-serial decimal addition straight from the correction rule.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output logic c, output logic e);
        int d;
        int da;
        int db;
        s = '0;
        c = 1'b0;
        e = 1'b0;
        for (int i = 0; i < 2 * NB; i++) begin
            da = int'(a[4*i +: 4]);
            db = int'(b[4*i +: 4]);
            if (da > 9 || db > 9) e = 1'b1;
            d = da + db + int'(c);
            if (d > 9) begin
                d = d + 6;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            s[4*i +: 4] = 4'(d % 16);
        end
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < 2 * NB; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Caller drives this just after a falling edge; returns in the done cycle.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_s, input logic exp_c, input logic exp_e,
                         input string tag);
        int cyc;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " err_cleared"}, 32'(err), 32'd0);
        check({tag, " sum_cleared"}, 32'(sum), 32'd0);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(NB));
        check({tag, " sum"}, 32'(sum), 32'(exp_s));
        check({tag, " cout"}, 32'(cout), 32'(exp_c));
        check({tag, " err"}, 32'(err), 32'(exp_e));
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_hold(input logic [W-1:0] exp_s, input logic exp_c, input string tag);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " sum_stable"}, 32'(sum), 32'(exp_s));
        check({tag, " cout_stable"}, 32'(cout), 32'(exp_c));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ms;
        logic         mc;
        logic         me;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           dones;

        vecs[0] = '{16'h0025, 16'h0052, 16'h0077, 1'b0, 1'b0};
        vecs[1] = '{16'h0099, 16'h0088, 16'h0187, 1'b0, 1'b0};
        vecs[2] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0};
        vecs[4] = '{16'h0099, 16'h0001, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{16'h00A0, 16'h0000, 16'h0100, 1'b0, 1'b1};
        vecs[6] = '{16'h1234, 16'h8765, 16'h9999, 1'b0, 1'b0};
        vecs[7] = '{16'h5000, 16'h5000, 16'h0000, 1'b1, 1'b0};

        // Reset values
        #3;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        check("reset err", 32'(err), 32'd0);

        // Start on the very first edge after reset release
        @(negedge clk);
        rst_n = 1'b1;
        do_op(vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].c, vecs[0].e, "first_after_reset");
        check_hold(vecs[0].s, vecs[0].c, "first_after_reset");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].e, $sformatf("vec%0d", i));
            check_hold(vecs[i].s, vecs[i].c, $sformatf("vec%0d", i));
        end

        // IDLE: operand changes without start leave the result alone
        @(negedge clk);
        op_a = 16'h4444;
        op_b = 16'h5555;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold sum", 32'(sum), 32'(vecs[7].s));
        check("idle_hold cout", 32'(cout), 32'(vecs[7].c));
        check("idle_hold busy", 32'(busy), 32'd0);

        // Back-to-back: start held high through the busy and done cycles
        @(negedge clk);
        op_a  = 16'h0093;
        op_b  = 16'h0012;
        start = 1'b1;
        @(posedge clk);
        #1;
        op_a = 16'h0001;
        op_b = 16'h0001;
        @(posedge clk);
        #1;
        check("b2b busy_mid", 32'(busy), 32'd1);
        check("b2b no_early_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check("b2b first_done", 32'(done), 32'd1);
        check("b2b first_sum", 32'(sum), 32'h0105);
        check("b2b first_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b second_accepted", 32'(busy), 32'd1);
        check("b2b done_dropped", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("b2b second_done", 32'(done), 32'd1);
        check("b2b second_sum", 32'(sum), 32'h0002);
        dones = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            if (busy) dones++;
        end
        check("b2b no_extra_op", 32'(dones), 32'd0);

        // Reset mid-operation
        @(negedge clk);
        op_a  = 16'h1234;
        op_b  = 16'h1111;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset sum", 32'(sum), 32'd0);
        check("midreset cout", 32'(cout), 32'd0);
        dones = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check("midreset no_done", 32'(dones), 32'd0);
        @(negedge clk);
        do_op(16'h0025, 16'h0052, 16'h0077, 1'b0, 1'b0, "after_midreset");

        // Randomised operations against the digit model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = W'($urandom);
                rb = W'($urandom);
            end else begin
                ra = rand_bcd();
                rb = rand_bcd();
            end
            model(ra, rb, ms, mc, me);
            @(negedge clk);
            do_op(ra, rb, ms, mc, me, $sformatf("rand%0d a=%h b=%h", i, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
